// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller.
// Holds the FSM state encoding and the operand-width legality check.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  function automatic bit width_legal(int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/FullAdder.sv
// One-bit full adder cell, shared bit-serially by serial_adder_ctrl.
// Ports: a, b, cin in; s (sum bit), cout (carry) out.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one FullAdder cell time-shared over WIDTH bits.
// Ports: start_valid/ready + a,b,cin in; sum,cout,ovf + done_valid/ready out.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             done_valid,
  input  logic             done_ready
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  generate
    if (!width_legal(WIDTH)) begin : g_bad_width
      $error("serial_adder_ctrl: WIDTH out of range");
    end
  endgenerate

  state_e state_q;
  state_e state_d;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             ovf_stg;
  logic             fa_s;
  logic             fa_cout;
  logic             accept;
  logic             last;

  FullAdder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last = (state_q == S_RUN) && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    accept      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        start_ready = 1'b1;
        accept      = start_valid;
        if (start_valid) state_d = S_RUN;
      end
      S_RUN: begin
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        done_valid = 1'b1;
        if (done_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_stg <= 1'b0;
    end else if (accept) begin
      a_sr    <= a;
      b_sr    <= b;
      sum_sr  <= '0;
      cnt_q   <= '0;
      carry_q <= cin;
    end else if (state_q == S_RUN) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      sum_sr  <= {fa_s, sum_sr[WIDTH-1:1]};
      carry_q <= fa_cout;
      if (last) begin
        ovf_stg <= carry_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // After the final RUN edge carry_q holds the MSB carry-out and
  // ovf_stg the carry into the MSB; both hold while idle/done.
  assign sum  = sum_sr;
  assign cout = carry_q;
  assign ovf  = ovf_stg ^ carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8).
// Random and directed operations checked against an arithmetic model.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         done_valid;
  logic         done_ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .done_valid  (done_valid),
    .done_ready  (done_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // {ovf, cout, sum[7:0]} from plain integer arithmetic
  function automatic logic [9:0] ref_add(int ua, int ub, int uc);
    int t;
    int sa;
    int sb;
    int ss;
    logic [9:0] r;
    t  = ua + ub + uc;
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    ss = sa + sb + uc;
    r[7:0] = t[7:0];
    r[8]   = (t >= 256);
    r[9]   = (ss > 127) || (ss < -128);
    return r;
  endfunction

  task automatic run_op(logic [7:0] xa, logic [7:0] xb,
                        logic xc, int hold);
    logic [9:0] e;
    int n;
    e = ref_add(int'(xa), int'(xb), int'(xc));
    chk("idle_ready", 32'(start_ready), 1);
    a = xa;
    b = xb;
    cin = xc;
    start_valid = 1'b1;
    done_ready = 1'b0;
    tick();
    start_valid = 1'b0;
    chk("ready_low_run", 32'(start_ready), 0);
    n = 0;
    while (!done_valid && n < 40) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(W));
    chk("sum", 32'(sum), 32'(e[7:0]));
    chk("cout", 32'(cout), 32'(e[8]));
    chk("ovf", 32'(ovf), 32'(e[9]));
    for (int i = 0; i < hold; i++) begin
      start_valid = 1'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      tick();
      chk("hold_sum", 32'(sum), 32'(e[7:0]));
      chk("hold_cout", 32'(cout), 32'(e[8]));
      chk("hold_ovf", 32'(ovf), 32'(e[9]));
      chk("hold_ready", 32'(start_ready), 0);
      chk("hold_valid", 32'(done_valid), 1);
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("back_idle", 32'(start_ready), 1);
    chk("valid_drop", 32'(done_valid), 0);
    chk("idle_sum", 32'(sum), 32'(e[7:0]));
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_ready"}, 32'(start_ready), 1);
    chk({tag, "_valid"}, 32'(done_valid), 0);
    chk({tag, "_sum"}, 32'(sum), 0);
    chk({tag, "_cout"}, 32'(cout), 0);
    chk({tag, "_ovf"}, 32'(ovf), 0);
  endtask

  initial begin
    logic [9:0] e;
    logic [9:0] exp_q[$];
    int acc_cyc[$];
    int nacc;
    int ndone;
    bit acc;

    rst = 1'b1;
    start_valid = 1'b0;
    done_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");
    rst = 1'b0;

    run_op(8'h35, 8'h4A, 1'b0, 5);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'h7F, 8'h01, 1'b1, 2);
    run_op(8'h80, 8'h80, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 1);

    // reset in the 4th RUN cycle
    a = 8'hAA;
    b = 8'h55;
    cin = 1'b0;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk_reset_vals("abort");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_novalid", 32'(done_valid), 0);
    end
    rst = 1'b0;
    run_op(8'h01, 8'h02, 1'b0, 0);

    for (int i = 0; i < 16; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
    end

    // back-to-back
    done_ready = 1'b1;
    start_valid = 1'b1;
    a = 8'($urandom);
    b = 8'($urandom);
    cin = 1'($urandom);
    nacc = 0;
    ndone = 0;
    for (int t = 0; t < 80 && ndone < 3; t++) begin
      acc = start_ready && start_valid;
      if (acc) begin
        exp_q.push_back(ref_add(int'(a), int'(b), int'(cin)));
        acc_cyc.push_back(cyc);
        nacc++;
      end
      tick();
      if (acc) begin
        if (nacc >= 3) start_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        cin = 1'($urandom);
      end
      if (done_valid) begin
        ndone++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("b2b_sum", 32'(sum), 32'(e[7:0]));
          chk("b2b_cout", 32'(cout), 32'(e[8]));
          chk("b2b_ovf", 32'(ovf), 32'(e[9]));
        end else begin
          chk("b2b_unexpected", 32'(ndone), 0);
        end
      end
    end
    start_valid = 1'b0;
    done_ready = 1'b0;
    chk("b2b_done_count", 32'(ndone), 3);
    chk("b2b_acc_count", 32'(acc_cyc.size()), 3);
    if (acc_cyc.size() == 3) begin
      chk("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 2));
      chk("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(W + 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller for the Flag Vending Machine datapath. It time-shares a single `FullAdder` cell across all bits of a WIDTH-bit operand pair: it loads the operands, presents one bit pair plus the registered carry per cycle, and collects the sum bits. It returns the sum, carry-out and signed overflow through a valid/ready result handshake. It replaces a WIDTH-wide ripple adder where area matters more than latency.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range 2..32.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_valid`  in  1  requester has an operand pair on `a`, `b`, `cin`.
- `start_ready`  out  1  block can accept a new operation.
- `a`  in  WIDTH  operand A, unsigned or two's complement.
- `b`  in  WIDTH  operand B.
- `cin`  in  1  carry-in for bit 0.
- `sum`  out  WIDTH  result, valid while `done_valid` is high.
- `cout`  out  1  carry out of bit WIDTH-1.
- `ovf`  out  1  signed overflow, equal to carry into the MSB XOR carry out of the MSB.
- `done_valid`  out  1  result available.
- `done_ready`  in  1  consumer takes the result.

## Operation
- FSM states:
  - IDLE: `start_ready`=1.
  - RUN: shifting.
  - DONE: `done_valid`=1.
- IDLE → RUN on `start_valid`&&`start_ready` (the accept edge).
  - Capture `a` and `b` into shift registers, set the carry register to `cin`, clear the bit counter and the sum shift register.
- Each RUN cycle:
  - The `FullAdder` sees the LSBs of the A and B shift registers and the carry register.
  - On the edge: shift `s` into the sum register MSB-first (right shift), shift A and B right by one, load the carry register with `cout`, and increment the counter.
  - On the cycle that processes bit WIDTH-1, capture the carry register value (carry into the MSB) into an `ovf` staging flop.
- RUN → DONE on the edge that processes bit WIDTH-1 (counter == WIDTH-1).
  - `sum` = the complete shift register, `cout` = final carry, `ovf` = staged carry-in XOR final carry.
- DONE → IDLE on `done_ready`. Outputs hold their values until the next accept.
- `start_valid` during RUN or DONE is ignored. The requester must hold it, and operands are not sampled.
- `done_ready` outside DONE has no effect.
- Arithmetic result: {`cout`,`sum`} = `a` + `b` + `cin`, computed modulo 2^(WIDTH+1).
- Counter width is $clog2(WIDTH). It never wraps because the exit fires at WIDTH-1.

## Timing
- Reset values: state IDLE, `start_ready`=1, `done_valid`=0, `sum`=0, `cout`=0, `ovf`=0, and all internal registers 0.
- `start_ready` and `done_valid` are decoded combinationally from the state register only. There is no input-to-output combinational path.
- Latency: `done_valid` rises exactly WIDTH cycles after the accept edge (WIDTH=8 gives 8 cycles).
- Throughput: one operation per WIDTH+2 cycles at best (accept, WIDTH RUN edges, one DONE cycle with `done_ready` high, back in IDLE). `start_ready` is low from the accept edge until the DONE→IDLE edge.
- A result stalls indefinitely in DONE while `done_ready`=0, with outputs stable.
- Asserting `rst` at any point, including mid-RUN or in DONE, aborts immediately to the reset values. The partial result is discarded and `done_valid` never pulses for the aborted operation.
- Deassertion of `rst` is assumed synchronous to `clk` by the top level. The first accept is possible on the first edge after release.

## Structure
- Shared package `serial_adder_pkg` holds:
  - the state enum (IDLE, RUN, DONE),
  - localparam encodings,
  - the WIDTH legality check constant.
- One sub-module: an instance of the existing `FullAdder`, reused unmodified as the bit cell.
- All control, shift and carry registers live in `serial_adder_ctrl`.

## Test plan
- Reset, then with WIDTH=8 drive a=8'h35, b=8'h4A, cin=0 → `done_valid` rises 8 cycles after accept; `sum`=8'h7F, `cout`=0, `ovf`=0.
- a=8'hFF, b=8'h01, cin=0 → `sum`=8'h00, `cout`=1, `ovf`=0.
- a=8'h7F, b=8'h01, cin=1 → `sum`=8'h81, `cout`=0, `ovf`=1.
- Hold `done_ready`=0 for 5 cycles after DONE → `sum`, `cout`, `ovf` stable and `start_ready`=0 throughout. Toggle `start_valid` during that time → no new capture.
- Assert `rst` on the 4th RUN cycle of a=8'hAA, b=8'h55 → all outputs return to reset values and `start_ready`=1. A following op a=8'h01, b=8'h02 → `sum`=8'h03.
- Back-to-back: keep `start_valid`=1 and `done_ready`=1 for 3 operations → each accepted exactly WIDTH+2 cycles apart, with results matching the reference model a+b+cin.
